// File: rtl/interleaver_pingpong_ctrl.sv
// Ping-pong buffer between the interleaver core and the QPSK modulator.
// Permuted single-bit writes fill one bank while the other bank streams out
// in ascending address order.
module interleaver_pingpong_ctrl #(
  parameter int unsigned Ncbps = 192,
  parameter int unsigned IW    = $clog2(Ncbps)
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          in_valid,
  input  logic          in_data,
  input  logic [IW-1:0] in_index,
  output logic          ready_buffer,
  input  logic          out_ready,
  output logic          out_valid,
  output logic          out_data,
  output logic          out_first,
  output logic          out_last,
  output logic          err_index
);

  localparam logic [IW-1:0] LastIdx = IW'(Ncbps - 1);
  // One bit wider than the index so the range check also works when Ncbps == 2**IW.
  localparam logic [IW:0]   DepthW  = (IW + 1)'(Ncbps);

  logic [Ncbps-1:0] bank0_q, bank1_q;
  logic [1:0]       full_q, full_d;
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [IW-1:0]    wr_cnt_q, wr_cnt_d;
  logic [IW-1:0]    rd_cnt_q, rd_cnt_d;
  logic             err_q, err_d;

  logic wr_acc, idx_ok, wr_commit, wr_done;
  logic rd_acc, rd_done, rd_bit;

  // Handshake decode for both sides.
  always_comb begin
    ready_buffer = ~full_q[wr_sel_q];
    out_valid    = full_q[rd_sel_q];
    wr_acc       = in_valid & ready_buffer;
    idx_ok       = ({1'b0, in_index} < DepthW);
    wr_commit    = wr_acc & idx_ok;
    wr_done      = wr_commit & (wr_cnt_q == LastIdx);
    rd_acc       = out_valid & out_ready;
    rd_done      = rd_acc & (rd_cnt_q == LastIdx);
  end

  // Next-state for counters, bank selects, full flags and the sticky error.
  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    err_d    = err_q | (wr_acc & ~idx_ok);
    if (wr_commit) begin
      wr_cnt_d = wr_done ? '0 : wr_cnt_q + IW'(1);
    end
    // Write and read completions always hit different banks, so both may land together.
    if (wr_done) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end
    if (rd_acc) begin
      rd_cnt_d = rd_done ? '0 : rd_cnt_q + IW'(1);
    end
    if (rd_done) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      full_q   <= 2'b00;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      err_q    <= err_d;
    end
  end

  // Bank storage: scatter write of the accepted bit, contents deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(Ncbps); i++) begin
      if (wr_commit && (in_index == IW'(i))) begin
        if (wr_sel_q) begin
          bank1_q[i] <= in_data;
        end else begin
          bank0_q[i] <= in_data;
        end
      end
    end
  end

  // Read mux plus output framing; data is masked so it reads 0 when nothing is valid.
  always_comb begin
    rd_bit = 1'b0;
    for (int i = 0; i < int'(Ncbps); i++) begin
      if (rd_cnt_q == IW'(i)) begin
        rd_bit = rd_sel_q ? bank1_q[i] : bank0_q[i];
      end
    end
    out_data  = out_valid & rd_bit;
    out_first = out_valid & (rd_cnt_q == '0);
    out_last  = out_valid & (rd_cnt_q == LastIdx);
    err_index = err_q;
  end

endmodule

// File: tb/tb_interleaver_pingpong_ctrl.sv
// Bench for interleaver_pingpong_ctrl: a cycle-by-cycle vector table on a
// 4-deep instance, then block-level sequences on the default 192-deep instance.
module tb_interleaver_pingpong_ctrl;

  localparam int N = 192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Full-size instance.
  logic       rst_n, in_valid, in_data, out_ready;
  logic [7:0] in_index;
  logic       ready_buffer, out_valid, out_data, out_first, out_last, err_index;

  interleaver_pingpong_ctrl #(.Ncbps(N)) dut (
    .clk          (clk),
    .resetN       (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_index     (in_index),
    .ready_buffer (ready_buffer),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_first    (out_first),
    .out_last     (out_last),
    .err_index    (err_index)
  );

  // Tiny instance for the hand-computed vector table.
  logic       s_rst_n, s_in_valid, s_in_data, s_out_ready;
  logic [2:0] s_in_index;
  logic       s_ready, s_ov, s_od, s_of, s_ol, s_err;

  interleaver_pingpong_ctrl #(.Ncbps(4), .IW(3)) dut_small (
    .clk          (clk),
    .resetN       (s_rst_n),
    .in_valid     (s_in_valid),
    .in_data      (s_in_data),
    .in_index     (s_in_index),
    .ready_buffer (s_ready),
    .out_ready    (s_out_ready),
    .out_valid    (s_ov),
    .out_data     (s_od),
    .out_first    (s_of),
    .out_last     (s_ol),
    .err_index    (s_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Row: inputs for the coming edge, outputs expected before that edge.
  typedef struct packed {
    logic       v;
    logic       d;
    logic [2:0] idx;
    logic       ordy;
    logic [5:0] exp;  // {ready_buffer, out_valid, out_first, out_last, out_data, err_index}
  } vec_t;

  vec_t vecs [21];

  // Block-level machinery for the full-size instance.
  typedef struct packed {
    logic       d;
    logic [7:0] idx;
  } wbeat_t;

  wbeat_t wq[$];
  bit     expq[$];
  int     wr_acc, rd_acc, cyc, pos, ordy_mode;
  bit     s_rb, prev_stall, prev_od, ov_seen, track;
  int     last_wr_cyc, first_ov_cyc, rb_low_cnt, bubble_cnt;

  function automatic logic [7:0] perm(input int k);
    return 8'(12 * (k % 16) + k / 16);
  endfunction

  // Queue one block; data_mode 0 uses k[0], otherwise random bits. bad_at inserts index 200.
  task automatic push_block(input int bad_at, input int data_mode);
    bit     e[N];
    wbeat_t b;
    for (int k = 0; k < N; k++) begin
      if (k == bad_at) begin
        b.d = 1'b1; b.idx = 8'd200;
        wq.push_back(b);
      end
      b.idx = perm(k);
      b.d   = (data_mode == 0) ? k[0] : 1'($urandom_range(0, 1));
      wq.push_back(b);
      e[b.idx] = b.d;
    end
    for (int j = 0; j < N; j++) expq.push_back(e[j]);
  endtask

  task automatic push_partial(input int n);
    wbeat_t b;
    for (int k = 0; k < n; k++) begin
      b.idx = perm(k);
      b.d   = 1'($urandom_range(0, 1));
      wq.push_back(b);
    end
  endtask

  // One cycle: sample at negedge, check, then drive inputs for the next edge.
  task automatic step();
    bit e;
    @(negedge clk);
    cyc++;
    s_rb = ready_buffer;
    if (prev_stall) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'(prev_od));
    end
    if (out_valid && !ov_seen) begin
      ov_seen      = 1'b1;
      first_ov_cyc = cyc;
    end
    if (track && wq.size() > 0 && !ready_buffer) rb_low_cnt++;
    if (track && ov_seen && !out_valid && expq.size() > 0) bubble_cnt++;
    in_valid = (wq.size() > 0);
    if (in_valid) begin
      in_data  = wq[0].d;
      in_index = wq[0].idx;
      if (ready_buffer) begin
        void'(wq.pop_front());
        wr_acc++;
        last_wr_cyc = cyc;
      end
    end
    case (ordy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL extra_beat: actual=beat at pos %0d required=no beat", pos);
      end else begin
        e = expq.pop_front();
        check($sformatf("data@%0d", pos), 32'(out_data), 32'(e));
        check($sformatf("first@%0d", pos), 32'(out_first), 32'((pos % N) == 0));
        check($sformatf("last@%0d", pos), 32'(out_last), 32'((pos % N) == N - 1));
      end
      pos++;
      rd_acc++;
    end
    prev_stall = out_valid && !out_ready;
    prev_od    = out_data;
  endtask

  task automatic drain(input int budget, input string name);
    int c = 0;
    while ((wq.size() > 0 || expq.size() > 0) && c < budget) begin
      step();
      c++;
    end
    check({name, "_drained"}, 32'(wq.size() + expq.size()), 32'd0);
    step();
    step();
  endtask

  task automatic clear_model();
    wq.delete();
    expq.delete();
    pos        = 0;
    prev_stall = 1'b0;
    wr_acc     = 0;
    rd_acc     = 0;
    ov_seen    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 1'b0;
    in_index = 8'd0;
    out_ready = 1'b0;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ready"}, 32'(ready_buffer), 32'd1);
    check({name, "_valid"}, 32'(out_valid), 32'd0);
    check({name, "_first"}, 32'(out_first), 32'd0);
    check({name, "_last"}, 32'(out_last), 32'd0);
    check({name, "_data"}, 32'(out_data), 32'd0);
    check({name, "_err"}, 32'(err_index), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 1'b0; in_index = 8'd0; out_ready = 1'b0;
    s_rst_n = 1'b0; s_in_valid = 1'b0; s_in_data = 1'b0; s_in_index = 3'd0; s_out_ready = 1'b0;
    cyc = 0; ordy_mode = 0; track = 1'b0;
    clear_model();

    // Depth-4 table: fill bank0 with a bad index, stall, both banks full, no-bypass free,
    // same-edge write/read completion, then idle with out_ready ignored.
    vecs[0]  = '{1'b1, 1'b1, 3'd2, 1'b1, 6'b100000};
    vecs[1]  = '{1'b1, 1'b0, 3'd0, 1'b1, 6'b100000};
    vecs[2]  = '{1'b1, 1'b1, 3'd5, 1'b1, 6'b100000};
    vecs[3]  = '{1'b1, 1'b1, 3'd3, 1'b1, 6'b100001};
    vecs[4]  = '{1'b1, 1'b1, 3'd1, 1'b1, 6'b100001};
    vecs[5]  = '{1'b1, 1'b1, 3'd0, 1'b0, 6'b111001};
    vecs[6]  = '{1'b1, 1'b0, 3'd1, 1'b1, 6'b111001};
    vecs[7]  = '{1'b1, 1'b1, 3'd2, 1'b1, 6'b110011};
    vecs[8]  = '{1'b1, 1'b0, 3'd3, 1'b0, 6'b110011};
    vecs[9]  = '{1'b1, 1'b1, 3'd0, 1'b1, 6'b010011};
    vecs[10] = '{1'b1, 1'b1, 3'd0, 1'b1, 6'b010111};
    vecs[11] = '{1'b1, 1'b0, 3'd3, 1'b1, 6'b111011};
    vecs[12] = '{1'b1, 1'b1, 3'd2, 1'b1, 6'b110001};
    vecs[13] = '{1'b1, 1'b0, 3'd1, 1'b1, 6'b110011};
    vecs[14] = '{1'b1, 1'b1, 3'd0, 1'b1, 6'b110101};
    vecs[15] = '{1'b0, 1'b0, 3'd0, 1'b1, 6'b111011};
    vecs[16] = '{1'b0, 1'b0, 3'd0, 1'b1, 6'b110001};
    vecs[17] = '{1'b0, 1'b0, 3'd0, 1'b1, 6'b110011};
    vecs[18] = '{1'b0, 1'b0, 3'd0, 1'b1, 6'b110101};
    vecs[19] = '{1'b0, 1'b0, 3'd0, 1'b1, 6'b100001};
    vecs[20] = '{1'b0, 1'b0, 3'd0, 1'b0, 6'b100001};

    @(negedge clk);
    @(negedge clk);
    s_rst_n = 1'b1;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'({s_ready, s_ov, s_of, s_ol, s_od, s_err}),
            32'(vecs[i].exp));
      s_in_valid  = vecs[i].v;
      s_in_data   = vecs[i].d;
      s_in_index  = vecs[i].idx;
      s_out_ready = vecs[i].ordy;
    end

    // T1: one permuted block at full rate.
    do_reset();
    check_reset_outputs("t1_rst");
    ordy_mode = 1;
    push_block(-1, 0);
    drain(1000, "t1");
    check("t1_latency", 32'(first_ov_cyc), 32'(last_wr_cyc + 1));
    check("t1_reads", 32'(rd_acc), 32'(N));

    // T2: reader stalled while three blocks are offered.
    clear_model();
    ordy_mode = 0;
    push_block(-1, 1);
    push_block(-1, 1);
    push_block(-1, 1);
    c = 0;
    while (wr_acc < 2 * N && c < 2000) begin step(); c++; end
    check("t2_filled", 32'(wr_acc), 32'(2 * N));
    step();
    check("t2_rb_low", 32'(s_rb), 32'd0);
    for (int i = 0; i < 5; i++) step();
    check("t2_stalled", 32'(wr_acc), 32'(2 * N));
    ordy_mode = 1;
    c = 0;
    while (rd_acc < N && c < 1000) begin step(); c++; end
    check("t2_rb_before_free", 32'(s_rb), 32'd0);
    step();
    check("t2_rb_after_free", 32'(s_rb), 32'd1);
    drain(2000, "t2");
    check("t2_reads", 32'(rd_acc), 32'(3 * N));

    // T3: four blocks back to back, both sides at full rate.
    clear_model();
    ordy_mode = 1;
    rb_low_cnt = 0;
    bubble_cnt = 0;
    track = 1'b1;
    for (int b = 0; b < 4; b++) push_block(-1, 1);
    drain(2000, "t3");
    track = 1'b0;
    check("t3_rb_never_low", 32'(rb_low_cnt), 32'd0);
    check("t3_no_bubbles", 32'(bubble_cnt), 32'd0);
    check("t3_reads", 32'(rd_acc), 32'(4 * N));

    // T4: random out_ready.
    clear_model();
    ordy_mode = 2;
    for (int b = 0; b < 3; b++) push_block(-1, 1);
    drain(5000, "t4");
    check("t4_reads", 32'(rd_acc), 32'(3 * N));

    // T5: out-of-range index on beat 10.
    do_reset();
    ordy_mode = 1;
    push_block(10, 1);
    c = 0;
    while (!ov_seen && c < 1000) begin step(); c++; end
    check("t5_err_set", 32'(err_index), 32'd1);
    check("t5_beats", 32'(wr_acc), 32'(N + 1));
    check("t5_latency", 32'(first_ov_cyc), 32'(last_wr_cyc + 1));
    drain(1000, "t5");
    check("t5_err_sticky", 32'(err_index), 32'd1);
    do_reset();
    check("t5_err_cleared", 32'(err_index), 32'd0);

    // T6: asynchronous reset in the middle of a second block.
    ordy_mode = 0;
    push_block(-1, 1);
    push_partial(100);
    c = 0;
    while (wr_acc < N + 100 && c < 1000) begin step(); c++; end
    ordy_mode = 1;
    c = 0;
    while (rd_acc < 50 && c < 1000) begin step(); c++; end
    check("t6_reads_before", 32'(rd_acc), 32'd50);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    push_block(-1, 1);
    drain(1000, "t6");
    check("t6_reads_after", 32'(rd_acc), 32'(N));
    check("t6_latency", 32'(first_ov_cyc), 32'(last_wr_cyc + 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/interleaver_pingpong_ctrl.md
Name: interleaver_pingpong_ctrl

Overview:
- Ping-pong buffer controller between the interleaver core and the QPSK modulator.
- The interleaver writes one bit per beat, each with a permuted address.
- This block scatters those bits into one of two Ncbps-bit banks. When a bank is complete, it streams that bank out in ascending address order.
- It drives the interleaver's ready_buffer input. It also lets the write of block n+1 overlap the read of block n.

Parameters:
- Ncbps, 192, bits per interleaved block (bank depth).
- IW, $clog2(Ncbps), width of index and counters (8 at default).

Ports:
- clk  input  1  system clock, rising edge.
- resetN  input  1  asynchronous active-low reset.
- in_valid  input  1  interleaver valid (valid_interleaver).
- in_data  input  1  interleaved bit (data_out).
- in_index  input  IW  target address of in_data (data_out_index).
- ready_buffer  output  1  controller can accept a write this cycle.
- out_ready  input  1  modulator ready.
- out_valid  output  1  out_data is valid.
- out_data  output  1  bit at address rd_cnt of the read bank.
- out_first  output  1  high with beat at address 0.
- out_last  output  1  high with beat at address Ncbps-1.
- err_index  output  1  sticky flag: a write arrived with in_index >= Ncbps.

Behaviour:
- State:
  - bank0/bank1: Ncbps bits each.
  - full[1:0]: one flag per bank.
  - wr_sel, rd_sel: 1 bit each.
  - wr_cnt, rd_cnt: IW bits each.
- Reset (async, resetN=0): full=00, wr_sel=0, rd_sel=0, wr_cnt=0, rd_cnt=0, err_index=0.
  - Outputs after reset: ready_buffer=1, out_valid=0, out_first=0, out_last=0, out_data=0.
  - Bank contents are don't-care and are not reset.
  - Reset mid-block discards both banks. The partial block is lost and no output is produced for it.
- Write side:
  - ready_buffer = !full[wr_sel], combinational.
  - Write accept = in_valid & ready_buffer.
  - On accept with in_index < Ncbps:
    - bank[wr_sel][in_index] <= in_data.
    - wr_cnt increments.
  - On accept with in_index >= Ncbps: the bit is dropped, wr_cnt is unchanged, err_index <= 1.
  - Accepted write with wr_cnt == Ncbps-1:
    - full[wr_sel] <= 1.
    - wr_sel toggles.
    - wr_cnt <= 0.
  - Duplicate indices are not detected. The block completes after Ncbps valid-index beats regardless of address pattern.
- Read side:
  - out_valid = full[rd_sel].
  - out_data = bank[rd_sel][rd_cnt], combinational read.
  - out_first = out_valid & (rd_cnt==0).
  - out_last = out_valid & (rd_cnt==Ncbps-1).
  - Read accept = out_valid & out_ready. On accept, rd_cnt increments.
  - On the accepted beat with rd_cnt == Ncbps-1:
    - full[rd_sel] <= 0.
    - rd_sel toggles.
    - rd_cnt <= 0.
  - out_data must hold stable while out_valid=1 and out_ready=0.
- Latency:
  - Completing write at edge N gives out_valid=1 in the cycle after edge N.
  - One block takes at least Ncbps cycles to drain.
  - With both sides at full rate, throughput is 1 bit/cycle sustained.
- Boundary conditions:
  - Both banks full: ready_buffer=0. Interleaver stalls until the read side frees a bank.
  - Freed bank: read completion at edge N gives ready_buffer=1 in the cycle after edge N. There is no same-cycle bypass.
  - Same-edge write completion (bank A) and read completion (bank B): both take effect at that edge. full goes from {B} to {A}.
  - The write side can never target a full bank, so reads are never corrupted.
  - Counters wrap only via the explicit Ncbps-1 compare, never by overflow of IW bits.
  - out_ready is ignored when out_valid=0.

Test Plan:
- Reset, then 192 beats with in_index = standard QPSK permutation of k=0..191, in_data = k[0], out_ready=1:
  - out_valid rises exactly 1 cycle after the 192nd write.
  - 192 bits stream out matching the inverse permutation.
  - out_first on beat 0, out_last on beat 191.
- out_ready=0 throughout while the interleaver streams 384 beats:
  - ready_buffer drops after beat 384.
  - Beat 385 is stalled.
  - Raising out_ready drains bank0 and then bank1 in order. ready_buffer re-rises 1 cycle after the first bank drains.
- Continuous streaming of 4 blocks, out_ready=1 always:
  - ready_buffer never drops.
  - Outputs are contiguous 768 beats with no bubbles between blocks after the first fill.
- Random out_ready toggling (50%):
  - out_data is stable while stalled.
  - No bit is lost or duplicated over 3 blocks; scoreboard matches.
- in_index=200 on beat 10 of a block:
  - err_index=1 and stays 1.
  - The block needs 193 total beats to complete.
  - err_index clears only on resetN.
- resetN pulsed low after 100 writes and 50 reads of a second block:
  - All outputs return to reset values immediately.
  - The next full block is delivered correctly from bank0.
